// File: rtl/dff_deserializer.sv
// Serial-to-parallel stage: hunts for SYNC_WORD, then packs each following WIDTH-bit group
// into a word presented on a one-deep valid/ready buffer with a sticky overflow flag.
module dff_deserializer #(
  parameter int                 WIDTH     = 8,
  parameter logic [WIDTH-1:0]   SYNC_WORD = 8'hA5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             data_in,
  input  logic             data_in_valid,
  input  logic             resync,
  output logic [WIDTH-1:0] data_out,
  output logic             data_out_valid,
  input  logic             data_out_ready,
  output logic             locked,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nx;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] w_sr_nx;
  logic [WIDTH-1:0] w_shifted;
  logic [CW-1:0]    r_bit_cnt;
  logic [CW-1:0]    w_bit_cnt_nx;
  logic [CW-1:0]    r_hunt_cnt;
  logic [CW-1:0]    w_hunt_cnt_nx;
  logic             w_word_done;

  logic [WIDTH-1:0] r_data_out;
  logic [WIDTH-1:0] w_data_out_nx;
  logic             r_data_out_valid;
  logic             w_data_out_valid_nx;
  logic             r_locked;
  logic             r_overflow;
  logic             w_overflow_nx;
  logic             w_accept;

  assign w_shifted = {r_sr[WIDTH-2:0], data_in};
  assign w_accept  = r_data_out_valid & data_out_ready;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= ST_HUNT;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // resync outranks both sync detection and word completion on the same edge
  always_comb begin
    w_state_nx    = r_state;
    w_sr_nx       = r_sr;
    w_bit_cnt_nx  = r_bit_cnt;
    w_hunt_cnt_nx = r_hunt_cnt;
    w_word_done   = 1'b0;
    if (resync) begin
      w_state_nx    = ST_HUNT;
      w_sr_nx       = {WIDTH{1'b0}};
      w_bit_cnt_nx  = {CW{1'b0}};
      w_hunt_cnt_nx = {CW{1'b0}};
    end else if (data_in_valid) begin
      w_sr_nx = w_shifted;
      case (r_state)
        ST_HUNT: begin
          if (r_hunt_cnt == CW'(WIDTH)) begin
            w_hunt_cnt_nx = r_hunt_cnt;
          end else begin
            w_hunt_cnt_nx = r_hunt_cnt + CW'(1);
          end
          // hunt_cnt+1 >= WIDTH, written so the sum cannot wrap the counter width
          if ((w_shifted == SYNC_WORD) && (r_hunt_cnt >= CW'(WIDTH - 1))) begin
            w_state_nx   = ST_LOCKED;
            w_bit_cnt_nx = {CW{1'b0}};
          end else begin
            w_state_nx   = ST_HUNT;
          end
        end
        ST_LOCKED: begin
          if (r_bit_cnt == CW'(WIDTH - 1)) begin
            w_word_done  = 1'b1;
            w_bit_cnt_nx = {CW{1'b0}};
          end else begin
            w_bit_cnt_nx = r_bit_cnt + CW'(1);
          end
        end
        default: begin
          w_state_nx = ST_HUNT;
        end
      endcase
    end else begin
      w_sr_nx = r_sr;
    end
  end

  // Output buffer: a finished word loads only if the slot is empty or draining this edge
  always_comb begin
    w_data_out_nx       = r_data_out;
    w_data_out_valid_nx = r_data_out_valid;
    w_overflow_nx       = r_overflow;
    if (w_word_done) begin
      if (!r_data_out_valid || w_accept) begin
        w_data_out_nx       = w_shifted;
        w_data_out_valid_nx = 1'b1;
      end else begin
        w_overflow_nx       = 1'b1;
      end
    end else if (w_accept) begin
      w_data_out_valid_nx = 1'b0;
    end else begin
      w_data_out_valid_nx = r_data_out_valid;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_sr             <= {WIDTH{1'b0}};
      r_bit_cnt        <= {CW{1'b0}};
      r_hunt_cnt       <= {CW{1'b0}};
      r_data_out       <= {WIDTH{1'b0}};
      r_data_out_valid <= 1'b0;
      r_locked         <= 1'b0;
      r_overflow       <= 1'b0;
    end else begin
      r_sr             <= w_sr_nx;
      r_bit_cnt        <= w_bit_cnt_nx;
      r_hunt_cnt       <= w_hunt_cnt_nx;
      r_data_out       <= w_data_out_nx;
      r_data_out_valid <= w_data_out_valid_nx;
      r_locked         <= (w_state_nx == ST_LOCKED);
      r_overflow       <= w_overflow_nx;
    end
  end

  assign data_out       = r_data_out;
  assign data_out_valid = r_data_out_valid;
  assign locked         = r_locked;
  assign overflow       = r_overflow;

endmodule

// File: tb/tb_dff_deserializer.sv
// Bench for dff_deserializer: two instances (SYNC_WORD A5 and 00) checked every cycle
// against a bit-window reference model, plus directed literal checks.
module tb_dff_deserializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a_din = 1'b0, a_dinv = 1'b0, a_rs = 1'b0, a_ready = 1'b0;
  logic [7:0] a_dout;
  logic       a_dv, a_locked, a_ovf;
  logic       b_din = 1'b0, b_dinv = 1'b0, b_rs = 1'b0, b_ready = 1'b0;
  logic [7:0] b_dout;
  logic       b_dv, b_locked, b_ovf;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  dff_deserializer #(.WIDTH(8), .SYNC_WORD(8'hA5)) dut_a (
    .clock(clk), .reset(rst_n), .data_in(a_din), .data_in_valid(a_dinv), .resync(a_rs),
    .data_out(a_dout), .data_out_valid(a_dv), .data_out_ready(a_ready),
    .locked(a_locked), .overflow(a_ovf));

  dff_deserializer #(.WIDTH(8), .SYNC_WORD(8'h00)) dut_b (
    .clock(clk), .reset(rst_n), .data_in(b_din), .data_in_valid(b_dinv), .resync(b_rs),
    .data_out(b_dout), .data_out_valid(b_dv), .data_out_ready(b_ready),
    .locked(b_locked), .overflow(b_ovf));

  // Reference model: "hunting" flag, count of bits since entering hunt, 8-bit window,
  // count of bits into the current word, and the one-slot output buffer.
  typedef struct packed {
    logic hunting;
    int   hbits;
    int   win;
    int   lbits;
    int   dout;
    logic dv;
    logic ovf;
  } m_t;

  m_t mA, mB;
  int qa_word[$];
  int qa_cyc[$];

  function automatic m_t mreset();
    m_t n = '0;
    n.hunting = 1'b1;
    return n;
  endfunction

  function automatic m_t mstep(m_t m, logic rn, logic din, logic dinv, logic rs, logic rdy, int sync);
    m_t   n = m;
    logic done = 1'b0;
    int   w = 0;
    logic acc;
    if (!rn) return mreset();
    acc = m.dv && rdy;
    if (rs) begin
      n.hunting = 1'b1; n.hbits = 0; n.win = 0; n.lbits = 0;
    end else if (dinv) begin
      n.win = ((m.win << 1) | int'(din)) & 255;
      if (m.hunting) begin
        n.hbits = m.hbits + 1;
        if (n.hbits >= 8 && n.win == sync) begin
          n.hunting = 1'b0; n.lbits = 0;
        end
      end else begin
        n.lbits = m.lbits + 1;
        if (n.lbits == 8) begin
          done = 1'b1; w = n.win; n.lbits = 0;
        end
      end
    end
    if (done) begin
      if (!m.dv || acc) begin n.dout = w; n.dv = 1'b1; end
      else n.ovf = 1'b1;
    end else if (acc) begin
      n.dv = 1'b0;
    end
    return n;
  endfunction

  initial begin
    mA = mreset();
    mB = mreset();
  end

  always @(posedge clk) begin
    cyc++;
    if (rst_n && mA.dv && a_ready) begin
      qa_word.push_back(mA.dout);
      qa_cyc.push_back(cyc);
    end
    mA = mstep(mA, rst_n, a_din, a_dinv, a_rs, a_ready, 32'hA5);
    mB = mstep(mB, rst_n, b_din, b_dinv, b_rs, b_ready, 32'h00);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("a_dout",   32'(a_dout),   32'(mA.dout[7:0]));
      check("a_dv",     32'(a_dv),     32'(mA.dv));
      check("a_locked", 32'(a_locked), 32'(!mA.hunting));
      check("a_ovf",    32'(a_ovf),    32'(mA.ovf));
      check("b_dout",   32'(b_dout),   32'(mB.dout[7:0]));
      check("b_dv",     32'(b_dv),     32'(mB.dv));
      check("b_locked", 32'(b_locked), 32'(!mB.hunting));
      check("b_ovf",    32'(b_ovf),    32'(mB.ovf));
    end
  end

  task automatic a_bit(input logic b);
    a_din = b; a_dinv = 1'b1;
    @(negedge clk);
    a_dinv = 1'b0;
  endtask

  task automatic a_word(input logic [7:0] w, input bit gaps);
    for (int i = 7; i >= 0; i--) begin
      a_bit(w[i]);
      if (gaps && i > 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
  endtask

  task automatic b_bit(input logic b);
    b_din = b; b_dinv = 1'b1;
    @(negedge clk);
    b_dinv = 1'b0;
  endtask

  task automatic b_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) b_bit(w[i]);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_a_dout", 32'(a_dout), 32'h0);
    check("rst_a_dv", 32'(a_dv), 32'h0);
    check("rst_a_locked", 32'(a_locked), 32'h0);
    check("rst_a_ovf", 32'(a_ovf), 32'h0);
    rst_n = 1'b1;

    // SYNC_WORD=00 instance: seven zeros are not enough, the eighth locks
    for (int i = 0; i < 7; i++) begin
      b_bit(1'b0);
      check("b_no_early_lock", 32'(b_locked), 32'h0);
    end
    b_bit(1'b0);
    check("b_lock_8th", 32'(b_locked), 32'h1);
    b_word(8'h5C);
    check("b_word", 32'(b_dout), 32'h5C);
    check("b_word_dv", 32'(b_dv), 32'h1);
    b_bit(1'b1); b_bit(1'b0); b_bit(1'b1);
    rst_n = 1'b0; b_din = 1'b1; b_dinv = 1'b1;
    @(negedge clk);
    check("b_rst_dout", 32'(b_dout), 32'h0);
    check("b_rst_dv", 32'(b_dv), 32'h0);
    check("b_rst_locked", 32'(b_locked), 32'h0);
    check("b_rst_ovf", 32'(b_ovf), 32'h0);
    rst_n = 1'b1; b_dinv = 1'b0;

    // Lock on A5, first word 3C
    a_ready = 1'b1;
    a_word(8'hA5, 1'b0);
    check("t1_locked", 32'(a_locked), 32'h1);
    a_word(8'h3C, 1'b0);
    check("t1_dout", 32'(a_dout), 32'h3C);
    check("t1_dv", 32'(a_dv), 32'h1);
    check("t1_ovf", 32'(a_ovf), 32'h0);

    // Backpressure: 11 held, 22 dropped
    @(negedge clk);
    a_ready = 1'b0;
    a_word(8'h11, 1'b0);
    a_word(8'h22, 1'b0);
    check("t2_hold", 32'(a_dout), 32'h11);
    check("t2_ovf", 32'(a_ovf), 32'h1);
    a_ready = 1'b1;
    @(negedge clk);
    a_ready = 1'b0;
    check("t2_dv_fall", 32'(a_dv), 32'h0);
    check("t2_dout_keep", 32'(a_dout), 32'h11);
    @(negedge clk);
    check("t2_no_22", 32'(a_dv), 32'h0);

    // Back-to-back words with ready held high
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    a_ready = 1'b1;
    a_word(8'hA5, 1'b0);
    qa_word.delete(); qa_cyc.delete();
    a_word(8'h01, 1'b0); a_word(8'h02, 1'b0); a_word(8'h03, 1'b0);
    @(negedge clk);
    check("t3_count", 32'(qa_word.size()), 32'd3);
    if (qa_word.size() == 3) begin
      check("t3_w0", 32'(qa_word[0]), 32'h01);
      check("t3_w1", 32'(qa_word[1]), 32'h02);
      check("t3_w2", 32'(qa_word[2]), 32'h03);
      check("t3_gap1", 32'(qa_cyc[1] - qa_cyc[0]), 32'd8);
      check("t3_gap2", 32'(qa_cyc[2] - qa_cyc[1]), 32'd8);
    end
    check("t3_ovf", 32'(a_ovf), 32'h0);

    // Gaps between valid bits
    a_word(8'hC3, 1'b1);
    check("t4_dout", 32'(a_dout), 32'hC3);
    check("t4_dv", 32'(a_dv), 32'h1);

    // resync on the last bit of a word discards it
    @(negedge clk);
    qa_word.delete(); qa_cyc.delete();
    for (int i = 7; i >= 1; i--) a_bit(1'(8'h96 >> i));
    a_rs = 1'b1;
    a_bit(1'b0);
    a_rs = 1'b0;
    check("t5_unlocked", 32'(a_locked), 32'h0);
    check("t5_no_word", 32'(a_dv), 32'h0);
    check("t5_ovf", 32'(a_ovf), 32'h0);
    a_word(8'h5A, 1'b0); a_word(8'hA5, 1'b0); a_word(8'h77, 1'b0);
    check("t5_dout", 32'(a_dout), 32'h77);
    @(negedge clk);
    check("t5_one_word", 32'(qa_word.size()), 32'd1);
    if (qa_word.size() == 1) check("t5_val", 32'(qa_word[0]), 32'h77);

    // Random traffic on both instances
    for (int n = 0; n < 3000; n++) begin
      rst_n   = ($urandom_range(0, 599) != 0);
      a_din   = 1'($urandom);
      a_dinv  = ($urandom_range(0, 3) != 0);
      a_rs    = ($urandom_range(0, 149) == 0);
      a_ready = 1'($urandom);
      b_din   = ($urandom_range(0, 2) == 0);
      b_dinv  = ($urandom_range(0, 3) != 0);
      b_rs    = ($urandom_range(0, 99) == 0);
      b_ready = 1'($urandom);
      @(negedge clk);
    end
    rst_n = 1'b1; a_dinv = 1'b0; b_dinv = 1'b0; a_rs = 1'b0; b_rs = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
